// File: rtl/temp_trace_plotter.sv
`default_nettype none
// ============================================================================
// temp_trace_plotter : 20-sample temperature history drawn as bars on a grid
// Rev 1.0
// ============================================================================
module temp_trace_plotter #(
   parameter int          N_COLS       = 20,
   parameter int          N_LEVELS     = 300,
   parameter int          CUADRILLA_XI = 212,
   parameter int          CUADRILLA_XF = 712,
   parameter int          CUADRILLA_YI = 184,
   parameter int          CUADRILLA_YF = 484,
   parameter int          COMMIT_LINE  = 490,
   parameter int          ALARM_LEVEL  = 250,
   parameter logic [11:0] BAR_COLOR    = 12'h0F0,
   parameter logic [11:0] ALARM_COLOR  = 12'hF00,
   parameter logic [11:0] GRID_COLOR   = 12'hFFF,
   parameter logic [11:0] BG_COLOR     = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [8:0]  sample_data,
   output logic        sample_ready,
   input  logic [10:0] hc,
   input  logic [10:0] vc,
   input  logic [4:0]  matrix_x,
   input  logic [8:0]  matrix_y,
   input  logic        lines,
   output logic [11:0] rgb,
   output logic        frame_commit
);

   localparam logic [8:0]  MAX_LVL = 9'(N_LEVELS - 1);
   localparam logic [8:0]  ALARM   = 9'(ALARM_LEVEL);
   localparam logic [4:0]  LAST    = 5'(N_COLS - 1);
   localparam logic [4:0]  FULL    = 5'(N_COLS);
   localparam logic [5:0]  COLS6   = 6'(N_COLS);

   logic [8:0]  live_q [N_COLS];
   logic [8:0]  disp_q [N_COLS];
   logic [4:0]  wr_ptr_q, wr_ptr_d;
   logic [4:0]  count_q, count_d;
   logic [4:0]  disp_ptr_q;
   logic [4:0]  disp_count_q;
   logic        in_region_q;
   logic [11:0] rgb_q, rgb_d;

   logic        commit;
   logic        wr_fire;
   logic [8:0]  wr_level;
   logic [5:0]  first_col;
   logic        empty;
   logic [5:0]  idx_sum;
   logic [5:0]  idx;
   logic [8:0]  level;
   logic        bar;

   assign commit       = (vc == 11'(COMMIT_LINE)) && (hc == 11'd0);
   assign sample_ready = !commit;
   assign frame_commit = commit;
   assign wr_fire      = sample_valid && sample_ready;
   assign wr_level     = (sample_data > MAX_LVL) ? MAX_LVL : sample_data;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (wr_fire) begin
         wr_ptr_d = (wr_ptr_q == LAST) ? 5'd0 : wr_ptr_q + 5'd1;
         count_d  = (count_q == FULL) ? count_q : count_q + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_COLS; i++) live_q[i] <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_fire) live_q[wr_ptr_q] <= wr_level;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Display bank only changes outside the grid, so a frame never mixes two histories.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_COLS; i++) disp_q[i] <= '0;
         disp_ptr_q   <= '0;
         disp_count_q <= '0;
      end else if (commit) begin
         for (int i = 0; i < N_COLS; i++) disp_q[i] <= live_q[i];
         disp_ptr_q   <= wr_ptr_q;
         disp_count_q <= count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_region_q <= 1'b0;
      else        in_region_q <= (hc > 11'(CUADRILLA_XI)) && (hc <= 11'(CUADRILLA_XF)) &&
                                 (vc > 11'(CUADRILLA_YI)) && (vc <= 11'(CUADRILLA_YF));
   end

   // ptr - count + (x - (N - count)) reduces to ptr + x - N, folded back into 0..N-1.
   assign first_col = COLS6 - {1'b0, disp_count_q};
   assign empty     = {1'b0, matrix_x} < first_col;
   assign idx_sum   = {1'b0, disp_ptr_q} + {1'b0, matrix_x};
   assign idx       = (idx_sum >= COLS6) ? idx_sum - COLS6 : idx_sum;
   assign level     = (idx < COLS6) ? disp_q[idx[4:0]] : 9'd0;
   assign bar       = in_region_q && !empty && (matrix_y >= (MAX_LVL - level));

   always_comb begin
      rgb_d = BG_COLOR;
      if (!in_region_q)        rgb_d = 12'h000;
      else if (bar)            rgb_d = (level >= ALARM) ? ALARM_COLOR : BAR_COLOR;
      else if (lines)          rgb_d = GRID_COLOR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb_q <= '0;
      else        rgb_q <= rgb_d;
   end

   assign rgb = rgb_q;

endmodule
`default_nettype wire

// File: doc/temp_trace_plotter.md
Name: temp_trace_plotter

Overview:
- Downstream consumer of the 20x300 grid template.
- Stores the last 20 temperature samples in a circular history. Each sample is a level 0..299, 10 levels per degree.
- Per pixel, uses the template's column index matrix_x, row index matrix_y and grid flag lines to produce a 12-bit RGB value for the VGA output mux.
- The displayed data is double-buffered and committed once per frame, so a bar never tears mid-frame.

Parameters:
- N_COLS, 20: history depth, equal to the number of template columns.
- N_LEVELS, 300: vertical levels; the maximum level is N_LEVELS-1.
- CUADRILLA_XI, 212: grid left edge. The region is hc in (XI, XF].
- CUADRILLA_XF, 712: grid right edge.
- CUADRILLA_YI, 184: grid top edge. The region is vc in (YI, YF].
- CUADRILLA_YF, 484: grid bottom edge.
- COMMIT_LINE, 490: vc value at which the live bank is copied to the display bank. It lies outside the grid.
- ALARM_LEVEL, 250: bar levels >= this value are drawn in ALARM_COLOR.
- BAR_COLOR, 12'h0F0 / ALARM_COLOR, 12'hF00 / GRID_COLOR, 12'hFFF / BG_COLOR, 12'h000.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  a new sample is offered
- sample_data  in  9  sample level 0..511; clamped on write
- sample_ready  out  1  the sample is accepted when valid && ready
- hc  in  11  horizontal pixel counter
- vc  in  11  vertical pixel counter
- matrix_x  in  5  template column index, registered (1 clk after hc)
- matrix_y  in  9  template row index, registered
- lines  in  1  template grid flag, aligned with matrix_x/y
- rgb  out  12  pixel colour, registered
- frame_commit  out  1  one-cycle pulse on the commit cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - Both banks cleared to 0.
  - wr_ptr=0, count=0, disp_ptr=0, disp_count=0.
  - rgb=0, frame_commit=0, sample_ready=1.
- Write handshake (live bank):
  - On sample_valid && sample_ready: live[wr_ptr] <= min(sample_data, 299).
  - wr_ptr advances 0..19 and wraps 19->0.
  - count increments and saturates at 20. Once full, the oldest entry is overwritten.
  - sample_valid held without ready leaves all state unchanged, and the sample is retained by the producer.
- Commit:
  - Occurs on the cycle where vc==COMMIT_LINE && hc==0.
  - Action: disp <= live (parallel 20x9 copy), disp_ptr <= wr_ptr, disp_count <= count, frame_commit=1 for that cycle.
  - sample_ready is 0 in the commit cycle only. A sample offered then is accepted on the next cycle, so the commit never sees a half-written state.
- Column mapping, display bank only:
  - empty = matrix_x < 20 - disp_count.
  - Otherwise idx = (disp_ptr - disp_count + (matrix_x - (20 - disp_count))) mod 20.
  - Result: the newest sample sits in column 19 and the history scrolls left. All arithmetic is 6-bit, with mod 20 done by a conditional subtract of 20 (or add, for the negative case).
- Region:
  - in_region = hc in (XI, XF] && vc in (YI, YF], computed from hc/vc and delayed 1 clk to align with matrix_x/y/lines.
- Bar:
  - bar = in_region && !empty && matrix_y >= 299 - disp[idx]. matrix_y 0 is the top row.
  - Level 0 lights only row 299. Level 299 lights the full column.
- Colour priority, registered 1 clk after matrix_x/y (2 clk after hc/vc):
  1. !in_region -> 0
  2. bar -> ALARM_COLOR if disp[idx] >= ALARM_LEVEL, else BAR_COLOR
  3. lines -> GRID_COLOR
  4. otherwise BG_COLOR
- Reset asserted mid-frame: rgb goes to 0 immediately, the history is lost, and the plot stays blank until the first commit after new samples arrive.

Test Plan:
- Reset, no samples, full frame -> rgb only GRID_COLOR or BG_COLOR inside the region, 0 outside; frame_commit pulses once per frame at vc=490, hc=0.
- Write 100 and 260, then commit -> column 18: rows 199..299 = 12'h0F0. Column 19: rows 39..299 = 12'hF00. Columns 0..17 show no bar.
- Write 25 samples with values 1..25, commit -> column 0 shows value 6 and column 19 shows value 25; count saturated at 20, wr_ptr=5.
- sample_data=400 -> stored as 299; the column is lit for all rows 0..299.
- sample_valid asserted exactly on the commit cycle -> sample_ready=0 that cycle. The sample is accepted the next cycle, is absent from the current display bank, and appears after the next commit.
- Samples written mid-frame (vc=300) -> the current frame's rgb is unchanged; the new bar appears only in the next frame.
- rst_n pulsed low at vc=300 -> rgb=0 asynchronously, sample_ready=1 after release, and the display stays blank for the following frame.
